// File: rtl/fetch_pkg.sv
// Shared widths, PC increment and the instruction-buffer entry layout for the fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } fetch_entry_t;

  // Branch targets are word addresses; any stray low bits are dropped.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer: registered write, head visible the cycle after the push.
// Flush beats push; the head output holds its last presented value while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_dat,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_vld,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  r_last;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign o_vld   = (r_count != '0);
  assign o_count = r_count;
  assign w_pop   = i_pop & o_vld;
  assign o_head  = o_vld ? r_mem[r_rd_ptr] : r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Remember what decode last saw so an empty buffer does not expose stale slots.
      if (o_vld) r_last <= r_mem[r_rd_ptr];
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (i_push) begin
          r_mem[r_wr_ptr] <= i_push_dat;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(i_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// PC owner and fetch issue to a 1-cycle imem; issue-to-id_valid is 2 cycles, redirect-to-target 3.
// Issue stalls once buffered plus in-flight instructions would exceed DEPTH, so nothing is lost.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;
  logic              r_kill;

  logic              w_pop;
  logic              w_push;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_occ;
  fetch_entry_t      w_push_dat;
  fetch_entry_t      w_head;

  assign w_pop = id_valid & id_ready;

  // Occupancy after this cycle's pop, counting the response already on its way.
  assign w_occ    = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign imem_req = !rst && !redirect_valid && (w_occ < (CW+1)'(DEPTH));
  assign imem_addr = r_pc;

  assign w_push = r_inflight && !r_kill && !redirect_valid && !rst;

  always_comb begin
    w_push_dat          = '0;
    w_push_dat.instr    = imem_rdata;
    w_push_dat.pc_plus4 = r_req_pc + PC_INC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      r_kill     <= redirect_valid & r_inflight;
      if (redirect_valid) begin
        r_pc <= align_word(redirect_pc);
      end else if (imem_req) begin
        r_pc     <= r_pc + PC_INC;
        r_req_pc <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_vld      (id_valid),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  assign id_instr    = w_head.instr;
  assign id_pc_plus4 = w_head.pc_plus4;

endmodule
